radar_input_conditioner: RTL

Front-end stage that conditions the raw ARP, ACP and TRIG radar signals before they reach the radar statistics and simulation logic. It synchronises each asynchronous input into the system clock domain, rejects glitches shorter than a programmable width, and emits clean levels plus one-cycle rising-edge strobes. It also derives the 1 µs reference (tick and square wave) that clocks the ARP period measurement, and it counts rejected glitches for diagnostics.

---
 rtl/radar_input_conditioner_if.sv | 32 +++
 rtl/radar_input_conditioner.sv | 126 ++++++++++++
 2 files changed

// File: rtl/radar_input_conditioner_if.sv
// Signal bundle between the radar front-end conditioner and its environment:
// raw asynchronous radar inputs in, clean levels, strobes, the 1 us timebase
// and the glitch diagnostics counter out.
interface radar_input_conditioner_if #(
    parameter int GLITCH_WIDTH = 16
);
    logic                    ARP_RAW;
    logic                    ACP_RAW;
    logic                    TRIG_RAW;
    logic                    GLITCH_CLR;
    logic                    ARP;
    logic                    ACP;
    logic                    TRIG;
    logic                    ARP_P;
    logic                    ACP_P;
    logic                    TRIG_P;
    logic                    US_TICK;
    logic                    US_CLK;
    logic [GLITCH_WIDTH-1:0] GLITCH_CNT;

    // Environment side: drives raw inputs and the clear, observes results.
    modport master (
        output ARP_RAW, ACP_RAW, TRIG_RAW, GLITCH_CLR,
        input  ARP, ACP, TRIG, ARP_P, ACP_P, TRIG_P, US_TICK, US_CLK, GLITCH_CNT
    );

    // Conditioner side.
    modport slave (
        input  ARP_RAW, ACP_RAW, TRIG_RAW, GLITCH_CLR,
        output ARP, ACP, TRIG, ARP_P, ACP_P, TRIG_P, US_TICK, US_CLK, GLITCH_CNT
    );
endinterface

// File: rtl/radar_input_conditioner.sv
// Radar input conditioner: two-flop synchronisers, per-channel persistence
// filters with rising-edge strobes, a saturating glitch counter shared by the
// ARP/ACP/TRIG channels, and a 1 us tick / square-wave divider.
// Channel index: 0 = ARP, 1 = ACP, 2 = TRIG.
module radar_input_conditioner #(
    parameter int FILTER_LEN   = 8,
    parameter int CLK_DIV      = 100,
    parameter int GLITCH_WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    radar_input_conditioner_if.slave bus
);
    localparam logic [7:0]              FC_LAST = 8'(FILTER_LEN - 1);
    localparam logic [15:0]             DC_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0]             DC_HALF = 16'(CLK_DIV / 2);
    localparam logic [GLITCH_WIDTH-1:0] GC_MAX  = {GLITCH_WIDTH{1'b1}};

    logic [2:0]              raw_s;
    logic [2:0]              s1_q, s1_d;
    logic [2:0]              s2_q, s2_d;
    logic [2:0][7:0]         fc_q, fc_d;
    logic [2:0]              clean_q, clean_d;
    logic [2:0]              pulse_q, pulse_d;
    logic [2:0]              glitch_s;
    logic [1:0]              glitch_sum_s;
    logic [GLITCH_WIDTH:0]   gcnt_ext_s;
    logic [GLITCH_WIDTH-1:0] gcnt_q, gcnt_d;
    logic [15:0]             dc_q, dc_d;
    logic                    tick_q, tick_d;
    logic                    usclk_q, usclk_d;

    assign raw_s = {bus.TRIG_RAW, bus.ACP_RAW, bus.ARP_RAW};

    // Two-stage synchroniser chain; only the second stage feeds the filters.
    always_comb begin
        s1_d = raw_s;
        s2_d = s1_q;
    end

    // Persistence filter: clean level follows s2 only after FILTER_LEN
    // consecutive disagreeing cycles; an early return marks a glitch.
    always_comb begin
        fc_d     = fc_q;
        clean_d  = clean_q;
        glitch_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (s2_q[i] == clean_q[i]) begin
                fc_d[i]     = 8'd0;
                glitch_s[i] = (fc_q[i] != 8'd0);
            end else if (fc_q[i] == FC_LAST) begin
                clean_d[i] = ~clean_q[i];
                fc_d[i]    = 8'd0;
            end else begin
                fc_d[i] = fc_q[i] + 8'd1;
            end
        end
        pulse_d = clean_d & ~clean_q;
    end

    // Glitch counter: add up to three per cycle, saturate, clear wins.
    always_comb begin
        glitch_sum_s = {1'b0, glitch_s[0]} + {1'b0, glitch_s[1]} + {1'b0, glitch_s[2]};
        gcnt_ext_s   = {1'b0, gcnt_q} + {{(GLITCH_WIDTH-1){1'b0}}, glitch_sum_s};
        if (bus.GLITCH_CLR) begin
            gcnt_d = {GLITCH_WIDTH{1'b0}};
        end else if (gcnt_ext_s[GLITCH_WIDTH]) begin
            gcnt_d = GC_MAX;
        end else begin
            gcnt_d = gcnt_ext_s[GLITCH_WIDTH-1:0];
        end
    end

    // Microsecond divider; tick and square wave are decoded from the next count.
    always_comb begin
        if (dc_q == DC_LAST) begin
            dc_d = 16'd0;
        end else begin
            dc_d = dc_q + 16'd1;
        end
        tick_d  = (dc_d == 16'd0);
        usclk_d = (dc_d >= DC_HALF);
    end

    // Synchroniser, filter and strobe state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q    <= 3'b000;
            s2_q    <= 3'b000;
            fc_q    <= {3{8'd0}};
            clean_q <= 3'b000;
            pulse_q <= 3'b000;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            fc_q    <= fc_d;
            clean_q <= clean_d;
            pulse_q <= pulse_d;
        end
    end

    // Glitch counter and divider state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gcnt_q  <= {GLITCH_WIDTH{1'b0}};
            dc_q    <= 16'd0;
            tick_q  <= 1'b0;
            usclk_q <= 1'b0;
        end else begin
            gcnt_q  <= gcnt_d;
            dc_q    <= dc_d;
            tick_q  <= tick_d;
            usclk_q <= usclk_d;
        end
    end

    assign bus.ARP        = clean_q[0];
    assign bus.ACP        = clean_q[1];
    assign bus.TRIG       = clean_q[2];
    assign bus.ARP_P      = pulse_q[0];
    assign bus.ACP_P      = pulse_q[1];
    assign bus.TRIG_P     = pulse_q[2];
    assign bus.US_TICK    = tick_q;
    assign bus.US_CLK     = usclk_q;
    assign bus.GLITCH_CNT = gcnt_q;
endmodule
